// File: rtl/issue_pkg.sv
// Shared types and latency lookup for the issue scoreboard.
package issue_pkg;

    typedef enum logic [1:0] {
        UnitAlu  = 2'd0,
        UnitMem  = 2'd1,
        UnitFpu  = 2'd2,
        UnitFdiv = 2'd3
    } unit_e;

    typedef enum logic [1:0] {
        CauseNone   = 2'd0,
        CauseRaw    = 2'd1,
        CauseWaw    = 2'd2,
        CauseStruct = 2'd3
    } stall_cause_e;

    typedef struct packed {
        logic       valid;
        logic [5:0] rd;
        unit_e      unit;
    } wb_slot_t;

    function automatic int unsigned lat_of(input unit_e unit, input int unsigned lat_alu,
                                           input int unsigned lat_mem, input int unsigned lat_fpu,
                                           input int unsigned lat_fdiv);
        case (unit)
            UnitAlu: return lat_alu;
            UnitMem: return lat_mem;
            UnitFpu: return lat_fpu;
            default: return lat_fdiv;
        endcase
    endfunction

endpackage

// File: rtl/wb_resv_shift.sv
// Write-back reservation window: shifts toward slot 0 every cycle and inserts
// a new reservation at the issuing unit's latency minus one.
module wb_resv_shift
    import issue_pkg::*;
#(
    parameter int unsigned WB_DEPTH = 8,
    parameter int unsigned IdxW     = $clog2(WB_DEPTH + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ins_en,
    input  logic [IdxW-1:0]     ins_idx,
    input  wb_slot_t            ins_slot,
    output wb_slot_t            head,
    output logic [WB_DEPTH:0]   slot_valid
);

    wb_slot_t slot_q [WB_DEPTH];
    wb_slot_t slot_d [WB_DEPTH];
    // One extra always-empty slot on top keeps the shift and lookups uniform.
    wb_slot_t slot_ext [WB_DEPTH+1];

    always_comb begin
        for (int i = 0; i < WB_DEPTH; i++) begin
            slot_ext[i] = slot_q[i];
        end
        slot_ext[WB_DEPTH] = '0;
    end

    always_comb begin
        for (int i = 0; i < WB_DEPTH; i++) begin
            slot_d[i] = slot_ext[i+1];
            if (ins_en && (IdxW'(i) == ins_idx)) begin
                slot_d[i] = ins_slot;
            end
        end
    end

    always_comb begin
        for (int i = 0; i <= WB_DEPTH; i++) begin
            slot_valid[i] = slot_ext[i].valid;
        end
    end

    assign head = slot_q[0];

    always_ff @(posedge clk) begin
        for (int i = 0; i < WB_DEPTH; i++) begin
            if (rst) begin
                slot_q[i] <= '0;
            end else begin
                slot_q[i] <= slot_d[i];
            end
        end
    end

endmodule

// File: rtl/issue_scoreboard.sv
// Issue-stage scoreboard: RAW/WAW/structural hazard check, busy tracking and
// write-port scheduling for ALU, MEM, FPU and FDIV results.
module issue_scoreboard
    import issue_pkg::*;
#(
    parameter int unsigned WB_DEPTH = 8,
    parameter int unsigned LAT_ALU  = 1,
    parameter int unsigned LAT_MEM  = 2,
    parameter int unsigned LAT_FPU  = 4,
    parameter int unsigned LAT_FDIV = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        iss_valid,
    input  logic [5:0]  iss_rs1,
    input  logic [5:0]  iss_rs2,
    input  logic        iss_rs1_used,
    input  logic        iss_rs2_used,
    input  logic [6:0]  iss_rd,
    input  logic [1:0]  iss_unit,
    output logic        iss_fire,
    output logic        iss_stall,
    output logic [1:0]  stall_cause,
    output logic        wb_valid,
    output logic [5:0]  wb_rd,
    output logic [1:0]  wb_unit,
    output logic [63:0] busy_vec
);

    localparam int unsigned IdxW = $clog2(WB_DEPTH + 1);
    localparam int unsigned CntW = $clog2(LAT_FDIV + 1);

    unit_e           unit;
    logic [IdxW-1:0] lat;
    logic [5:0]      rd;
    logic            rd_eff;
    wb_slot_t        head;
    wb_slot_t        ins_slot;
    logic [WB_DEPTH:0] slot_valid;
    logic [63:0]     busy_q, busy_d;
    logic [CntW-1:0] fdiv_cnt_q, fdiv_cnt_d;
    logic            raw, waw, port_conf, unit_conf, hazard;
    stall_cause_e    cause;

    assign unit   = unit_e'(iss_unit);
    assign lat    = IdxW'(lat_of(unit, LAT_ALU, LAT_MEM, LAT_FPU, LAT_FDIV));
    assign rd     = iss_rd[5:0];
    assign rd_eff = iss_rd[6] & (rd != 6'd0);

    // A register retiring this cycle is forwarded, so it does not block issue.
    assign raw = (iss_rs1_used & busy_q[iss_rs1] & ~(head.valid & (head.rd == iss_rs1)))
               | (iss_rs2_used & busy_q[iss_rs2] & ~(head.valid & (head.rd == iss_rs2)));
    assign waw       = rd_eff & busy_q[rd] & ~(head.valid & (head.rd == rd));
    assign port_conf = rd_eff & slot_valid[lat];
    assign unit_conf = (unit == UnitFdiv) & (fdiv_cnt_q != '0);
    assign hazard    = raw | waw | port_conf | unit_conf;

    assign iss_fire  = iss_valid & ~flush & ~rst & ~hazard;
    assign iss_stall = iss_valid & ~flush & ~iss_fire;

    always_comb begin
        cause = CauseNone;
        if (iss_stall) begin
            if (raw) begin
                cause = CauseRaw;
            end else if (waw) begin
                cause = CauseWaw;
            end else if (port_conf || unit_conf) begin
                cause = CauseStruct;
            end
        end
    end
    assign stall_cause = cause;

    assign ins_slot = '{valid: 1'b1, rd: rd, unit: unit};

    wb_resv_shift #(
        .WB_DEPTH (WB_DEPTH),
        .IdxW     (IdxW)
    ) u_resv (
        .clk        (clk),
        .rst        (rst),
        .ins_en     (iss_fire & rd_eff),
        .ins_idx    (lat - IdxW'(1)),
        .ins_slot   (ins_slot),
        .head       (head),
        .slot_valid (slot_valid)
    );

    assign wb_valid = head.valid;
    assign wb_rd    = head.rd;
    assign wb_unit  = head.unit;
    assign busy_vec = busy_q;

    // Clear before set so a same-edge set on the retiring register wins.
    always_comb begin
        busy_d = busy_q;
        if (head.valid) begin
            busy_d[head.rd] = 1'b0;
        end
        if (iss_fire && rd_eff) begin
            busy_d[rd] = 1'b1;
        end
    end

    always_comb begin
        fdiv_cnt_d = fdiv_cnt_q;
        if (iss_fire && (unit == UnitFdiv)) begin
            fdiv_cnt_d = CntW'(LAT_FDIV - 1);
        end else if (fdiv_cnt_q != '0) begin
            fdiv_cnt_d = fdiv_cnt_q - CntW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q     <= '0;
            fdiv_cnt_q <= '0;
        end else begin
            busy_q     <= busy_d;
            fdiv_cnt_q <= fdiv_cnt_d;
        end
    end

endmodule

// File: tb/tb_issue_scoreboard.sv
// Directed self-checking bench for issue_scoreboard with hand-computed expectations.
module tb_issue_scoreboard;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        iss_valid;
    logic [5:0]  iss_rs1, iss_rs2;
    logic        iss_rs1_used, iss_rs2_used;
    logic [6:0]  iss_rd;
    logic [1:0]  iss_unit;
    logic        iss_fire, iss_stall;
    logic [1:0]  stall_cause;
    logic        wb_valid;
    logic [5:0]  wb_rd;
    logic [1:0]  wb_unit;
    logic [63:0] busy_vec;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    issue_scoreboard dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .iss_valid    (iss_valid),
        .iss_rs1      (iss_rs1),
        .iss_rs2      (iss_rs2),
        .iss_rs1_used (iss_rs1_used),
        .iss_rs2_used (iss_rs2_used),
        .iss_rd       (iss_rd),
        .iss_unit     (iss_unit),
        .iss_fire     (iss_fire),
        .iss_stall    (iss_stall),
        .stall_cause  (stall_cause),
        .wb_valid     (wb_valid),
        .wb_rd        (wb_rd),
        .wb_unit      (wb_unit),
        .busy_vec     (busy_vec)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next edge; inputs change here, checks follow after #3.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    task automatic drive(input logic v, input logic [1:0] u, input logic [6:0] rd,
                         input logic [5:0] rs1, input logic u1,
                         input logic [5:0] rs2, input logic u2);
        iss_valid    = v;
        iss_unit     = u;
        iss_rd       = rd;
        iss_rs1      = rs1;
        iss_rs1_used = u1;
        iss_rs2      = rs2;
        iss_rs2_used = u2;
    endtask

    task automatic idle();
        drive(1'b0, 2'd0, 7'h00, 6'd0, 1'b0, 6'd0, 1'b0);
    endtask

    initial begin
        rst   = 1'b1;
        flush = 1'b0;
        drive(1'b1, 2'd0, 7'h45, 6'd0, 1'b0, 6'd0, 1'b0);
        tick();
        settle();
        check_eq("rst_no_fire", iss_fire, 0);
        check_eq("rst_wb_valid", wb_valid, 0);
        check_eq("rst_wb_rd", wb_rd, 0);
        check_eq("rst_busy", busy_vec, 0);
        tick();
        rst = 1'b0;

        // ALU x5 then dependent ALU x6 via bypass
        drive(1'b1, 2'd0, 7'h45, 6'd0, 1'b0, 6'd0, 1'b0);
        settle();
        check_eq("alu0_fire", iss_fire, 1);
        tick();
        drive(1'b1, 2'd0, 7'h46, 6'd5, 1'b1, 6'd0, 1'b0);
        settle();
        check_eq("alu1_fire", iss_fire, 1);
        check_eq("alu1_stall", iss_stall, 0);
        check_eq("alu1_wb_valid", wb_valid, 1);
        check_eq("alu1_wb_rd", wb_rd, 5);
        check_eq("alu1_wb_unit", wb_unit, 0);
        tick();
        idle();
        settle();
        check_eq("alu2_wb_rd", wb_rd, 6);
        tick();
        settle();
        check_eq("alu3_busy", busy_vec, 0);
        check_eq("alu3_wb_valid", wb_valid, 0);

        // Load x7, dependent ALU stalls one cycle
        tick();
        drive(1'b1, 2'd1, 7'h47, 6'd0, 1'b0, 6'd0, 1'b0);
        settle();
        check_eq("ld0_fire", iss_fire, 1);
        tick();
        drive(1'b1, 2'd0, 7'h48, 6'd7, 1'b1, 6'd0, 1'b0);
        settle();
        check_eq("ld1_fire", iss_fire, 0);
        check_eq("ld1_stall", iss_stall, 1);
        check_eq("ld1_cause", stall_cause, 1);
        check_eq("ld1_busy7", busy_vec[7], 1);
        tick();
        settle();
        check_eq("ld2_fire", iss_fire, 1);
        check_eq("ld2_cause", stall_cause, 0);
        check_eq("ld2_wb_rd", wb_rd, 7);
        check_eq("ld2_wb_unit", wb_unit, 1);
        check_eq("ld2_busy7", busy_vec[7], 1);
        tick();
        idle();
        settle();
        check_eq("ld3_busy7", busy_vec[7], 0);
        check_eq("ld3_busy8", busy_vec[8], 1);
        tick();

        // FPU f3 then ALU x9 colliding on the write port
        drive(1'b1, 2'd2, 7'h63, 6'd0, 1'b0, 6'd0, 1'b0);
        settle();
        check_eq("fpu0_fire", iss_fire, 1);
        tick();
        idle();
        settle();
        check_eq("fpu1_busy35", busy_vec[35], 1);
        tick();
        tick();
        drive(1'b1, 2'd0, 7'h49, 6'd0, 1'b0, 6'd0, 1'b0);
        settle();
        check_eq("fpu3_fire", iss_fire, 0);
        check_eq("fpu3_cause", stall_cause, 3);
        tick();
        settle();
        check_eq("fpu4_fire", iss_fire, 1);
        check_eq("fpu4_wb_rd", wb_rd, 35);
        check_eq("fpu4_wb_unit", wb_unit, 2);
        tick();
        idle();
        settle();
        check_eq("fpu5_wb_rd", wb_rd, 9);
        check_eq("fpu5_wb_unit", wb_unit, 0);
        tick();

        // FDIV, store slips in, second FDIV waits for the unit
        drive(1'b1, 2'd3, 7'h61, 6'd0, 1'b0, 6'd0, 1'b0);
        settle();
        check_eq("fdiv0_fire", iss_fire, 1);
        tick();
        drive(1'b1, 2'd1, 7'h00, 6'd1, 1'b1, 6'd2, 1'b1);
        settle();
        check_eq("store1_fire", iss_fire, 1);
        tick();
        drive(1'b1, 2'd3, 7'h62, 6'd0, 1'b0, 6'd0, 1'b0);
        for (int t = 2; t <= 7; t++) begin
            settle();
            check_eq($sformatf("fdiv%0d_cause", t), stall_cause, 3);
            tick();
        end
        settle();
        check_eq("fdiv8_fire", iss_fire, 1);
        check_eq("fdiv8_wb_rd", wb_rd, 33);
        check_eq("fdiv8_wb_unit", wb_unit, 3);
        tick();
        idle();
        for (int t = 0; t < 9; t++) tick();
        settle();
        check_eq("fdiv_drain_busy", busy_vec, 0);

        // WAW: load x11 then ALU writing x11
        drive(1'b1, 2'd1, 7'h4b, 6'd0, 1'b0, 6'd0, 1'b0);
        tick();
        drive(1'b1, 2'd0, 7'h4b, 6'd0, 1'b0, 6'd0, 1'b0);
        settle();
        check_eq("waw1_cause", stall_cause, 2);
        tick();
        settle();
        check_eq("waw2_fire", iss_fire, 1);
        tick();
        idle();
        tick();

        // Flush kills the dependent op; the load still retires
        drive(1'b1, 2'd1, 7'h44, 6'd0, 1'b0, 6'd0, 1'b0);
        tick();
        flush = 1'b1;
        drive(1'b1, 2'd0, 7'h4a, 6'd4, 1'b1, 6'd0, 1'b0);
        settle();
        check_eq("flush_fire", iss_fire, 0);
        check_eq("flush_stall", iss_stall, 0);
        check_eq("flush_cause", stall_cause, 0);
        tick();
        flush = 1'b0;
        idle();
        settle();
        check_eq("flush_wb_valid", wb_valid, 1);
        check_eq("flush_wb_rd", wb_rd, 4);
        tick();
        settle();
        check_eq("flush_busy", busy_vec, 0);

        // x0 is never reserved; f0 is
        drive(1'b1, 2'd0, 7'h40, 6'd0, 1'b0, 6'd0, 1'b0);
        settle();
        check_eq("x0_fire", iss_fire, 1);
        tick();
        drive(1'b1, 2'd0, 7'h60, 6'd0, 1'b0, 6'd0, 1'b0);
        settle();
        check_eq("x0_busy", busy_vec, 0);
        check_eq("x0_wb_valid", wb_valid, 0);
        tick();
        idle();
        settle();
        check_eq("f0_busy", busy_vec, 64'h1_0000_0000);
        check_eq("f0_wb_rd", wb_rd, 32);
        tick();

        // Reset mid-operation discards the FDIV in flight
        drive(1'b1, 2'd3, 7'h65, 6'd0, 1'b0, 6'd0, 1'b0);
        settle();
        check_eq("rfdiv0_fire", iss_fire, 1);
        tick();
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        drive(1'b1, 2'd3, 7'h66, 6'd0, 1'b0, 6'd0, 1'b0);
        settle();
        check_eq("rfdiv2_busy", busy_vec, 0);
        check_eq("rfdiv2_wb_valid", wb_valid, 0);
        check_eq("rfdiv2_fire", iss_fire, 1);
        tick();
        idle();
        for (int t = 0; t < 6; t++) tick();
        settle();
        check_eq("rfdiv_no_stale_wb", wb_valid, 0);
        check_eq("rfdiv_busy38", busy_vec[38], 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/issue_scoreboard.md
# issue_scoreboard

Issue-stage scheduler between decode and the execution units. Tracks outstanding writes to the 64-entry unified register file (index[5]=float, index[4:0]=register), detects RAW/WAW hazards, and arbitrates the single register-file write port among ALU, memory, FPU and FDIV results. Decode presents one instruction per cycle; this block returns a fire/stall decision and drives the write-back selection for each cycle.

## Interface
Parameters:
- WB_DEPTH, 8: reservation window depth, in slots; must be ≥ every latency below
- LAT_ALU, 1: ALU result latency, in cycles
- LAT_MEM, 2: load latency
- LAT_FPU, 4: pipelined FPU latency
- LAT_FDIV, 8: FDIV/FSQRT latency; this unit is non-pipelined

Ports (reset rst, synchronous, active-high; clock clk):
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- flush  in  1  kill the instruction presented this cycle
- iss_valid  in  1  decode presents an instruction
- iss_rs1, iss_rs2  in  6  source indices
- iss_rs1_used, iss_rs2_used  in  1  source is actually read
- iss_rd  in  7  [6]=writes rd, [5:0]=index
- iss_unit  in  2  0 ALU, 1 MEM, 2 FPU, 3 FDIV
- iss_fire  out  1  instruction accepted this cycle (combinational)
- iss_stall  out  1  iss_valid & ~flush & ~iss_fire
- stall_cause  out  2  0 none, 1 RAW, 2 WAW, 3 structural
- wb_valid  out  1  a write-back is due this cycle
- wb_rd  out  6  write-back destination
- wb_unit  out  2  unit that supplies the write-back data (write-port mux select)
- busy_vec  out  64  pending-write bit per register

## Operation
- L = the latency of iss_unit. rd_eff = iss_rd[6] & (iss_rd[5:0] != 0). Integer x0 is never reserved; f0 (index 32) is reserved normally.
- RAW: a used source rs with busy[rs] = 1, unless wb_valid & wb_rd == rs. A register retiring this cycle is covered by the WB bypass.
- WAW: rd_eff & busy[rd] = 1, unless wb_valid & wb_rd == rd.
- Structural:
  - Port conflict: rd_eff & slot[L].valid. slot[WB_DEPTH] is always empty.
  - Unit conflict: iss_unit == FDIV & fdiv_cnt != 0. This applies to FDIV with or without rd.
- iss_fire = iss_valid & ~flush & ~rst & no hazard.
- stall_cause priority: RAW > WAW > structural. It is 0 whenever iss_stall = 0.
- Reservation shift register slot[0..WB_DEPTH-1], each slot {valid, rd[5:0], unit[1:0]}. Every cycle: slot[i] ← slot[i+1], top slot ← empty. On fire & rd_eff, slot[L-1] ← {1, rd, unit}, written after the shift.
- wb_* = slot[0]. An instruction fired at cycle t appears on wb_* at cycle t+L.
- busy[r]:
  - Set at the clock edge after fire & rd_eff.
  - Cleared at the edge ending the cycle in which slot[0] holds r.
  - If set and clear hit the same register on the same edge, set wins.
- fdiv_cnt: loaded with LAT_FDIV-1 on FDIV fire, decrements to 0, saturates at 0.
- flush: iss_fire = 0, iss_stall = 0, stall_cause = 0. In-flight reservations, busy bits and fdiv_cnt are not cancelled; they still retire.
- Stores and branches (rd_eff = 0) check RAW only, plus the FDIV unit conflict if applicable. They reserve nothing.

## Timing
- Reset: all slots invalid, busy_vec = 0, fdiv_cnt = 0, wb_valid = 0, wb_rd = 0, wb_unit = 0. iss_fire = 0 while rst is high.
- Reset mid-operation discards all reservations immediately; no write-back is reported afterwards.
- Hazard check and iss_fire are combinational from the inputs and registered state, with zero-cycle decision latency. All state updates on posedge clk.
- Back-to-back dependent ALU ops (L=1) issue without a stall, via the WB bypass.
- A dependent op after MEM stalls 1 cycle. A dependent op after FPU stalls 3 cycles.

## Structure
- Package issue_pkg holds: unit_e (ALU/MEM/FPU/FDIV), stall_cause_e, the wb_slot_t struct {valid, rd, unit}, and a latency lookup function parameterised by the LAT_* values.
- One sub-module: wb_resv_shift. It holds the slot array, performs the shift and insert at depth L-1, and exposes slot[0] and per-slot valid bits for the conflict check.
- Busy vector, FDIV counter and hazard logic live in issue_scoreboard.

## Test plan
- Reset, then ALU add x5 at t0, then ALU add using rs1=x5 at t1 -> both fire; wb_rd=5, wb_unit=0 at t1; wb_rd of the second op at t2; no stall.
- MEM load x7 at t0, then ALU reading x7 -> stall_cause=1 at t1 only, fire at t2; busy_vec[7] is 1 during t1–t2 and 0 at t3.
- FPU write f3 (idx 35) at t0, then ALU write x9 at t3 -> port conflict at t3 (both due at t4): stall_cause=3 at t3, fire at t4, wb at t5.
- FDIV at t0, second FDIV at t1 -> stalls with cause 3 through t7, fires at t8. A store presented at t1 (no rd) fires immediately.
- Load x4 at t0, flush with a dependent op at t1 -> iss_fire=0, iss_stall=0; wb_rd=4 still appears at t2.
- Instruction writing x0 -> fires, busy_vec stays 0, no wb_valid. Assert rst at t1 after a FDIV at t0 -> slots, busy_vec and fdiv_cnt are zero at t2, and a new FDIV fires at t2.
